// File: rtl/alu_exec_unit_if.sv
// Execute-stage bundle: operand, forwarding and decode inputs towards the ALU,
// plus the combinational and registered ALU results coming back.
interface alu_exec_unit_if;
    logic [31:0] reg_a;
    logic [31:0] reg_b;
    logic [31:0] wb_data;
    logic [31:0] mem_alu;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [31:0] imm_value;
    logic        alu_src;
    logic [1:0]  aluop;
    logic        andi;
    logic        ori;
    logic        addi;
    logic        slti;
    logic [4:0]  shamt;
    logic [3:0]  alu_con;
    logic [31:0] alu_out;
    logic        overflow;
    logic        zero;
    logic [31:0] alu_out_q;
    logic [31:0] store_data_q;
    logic        overflow_q;

    modport master (
        output reg_a, reg_b, wb_data, mem_alu, fwd_a, fwd_b, imm_value, alu_src,
               aluop, andi, ori, addi, slti, shamt,
        input  alu_con, alu_out, overflow, zero, alu_out_q, store_data_q, overflow_q
    );

    modport slave (
        input  reg_a, reg_b, wb_data, mem_alu, fwd_a, fwd_b, imm_value, alu_src,
               aluop, andi, ori, addi, slti, shamt,
        output alu_con, alu_out, overflow, zero, alu_out_q, store_data_q, overflow_q
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute stage: forwarding muxes, ALU control decode, 32-bit ALU and the
// pipeline register carrying the result, store data and overflow onward.
module alu_exec_unit (
    input  logic           clock,
    input  logic           reset,
    alu_exec_unit_if.slave bus
);
    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_NOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001,
        ALU_SLTU = 4'b1010
    } alu_op_e;

    logic [31:0] w_src_a;
    logic [31:0] w_src_b;
    logic [31:0] w_alu_b;
    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic [31:0] w_result;
    logic        w_ovf;
    alu_op_e     w_con;

    logic [31:0] r_alu_out_q;
    logic [31:0] r_store_data_q;
    logic        r_overflow_q;

    // Operand A forwarding select
    always_comb begin
        w_src_a = '0;
        case (bus.fwd_a)
            2'b00:   w_src_a = bus.reg_a;
            2'b01:   w_src_a = bus.wb_data;
            2'b10:   w_src_a = bus.mem_alu;
            default: w_src_a = '0;
        endcase
    end

    // Operand B forwarding select (this value is also the store data)
    always_comb begin
        w_src_b = '0;
        case (bus.fwd_b)
            2'b00:   w_src_b = bus.reg_b;
            2'b01:   w_src_b = bus.wb_data;
            2'b10:   w_src_b = bus.mem_alu;
            default: w_src_b = '0;
        endcase
    end

    assign w_alu_b = bus.alu_src ? bus.imm_value : w_src_b;

    // ALU control decode from main-decoder op, funct field and immediate flags
    always_comb begin
        w_con = ALU_ADD;
        case (bus.aluop)
            2'b00: w_con = ALU_ADD;
            2'b01: w_con = ALU_SUB;
            2'b10: begin
                case (bus.imm_value[5:0])
                    6'b100000, 6'b100001: w_con = ALU_ADD;
                    6'b100010, 6'b100011: w_con = ALU_SUB;
                    6'b100100:            w_con = ALU_AND;
                    6'b100101:            w_con = ALU_OR;
                    6'b100110:            w_con = ALU_XOR;
                    6'b100111:            w_con = ALU_NOR;
                    6'b101010:            w_con = ALU_SLT;
                    6'b101011:            w_con = ALU_SLTU;
                    6'b000000:            w_con = ALU_SLL;
                    6'b000010:            w_con = ALU_SRL;
                    6'b000011:            w_con = ALU_SRA;
                    default:              w_con = ALU_ADD;
                endcase
            end
            default: begin
                if (bus.andi)      w_con = ALU_AND;
                else if (bus.ori)  w_con = ALU_OR;
                else if (bus.addi) w_con = ALU_ADD;
                else if (bus.slti) w_con = ALU_SLT;
                else               w_con = ALU_ADD;
            end
        endcase
    end

    assign w_sum  = w_src_a + w_alu_b;
    assign w_diff = w_src_a - w_alu_b;

    // ALU result and signed overflow; overflow only meaningful for ADD/SUB
    always_comb begin
        w_result = '0;
        w_ovf    = 1'b0;
        case (w_con)
            ALU_AND:  w_result = w_src_a & w_alu_b;
            ALU_OR:   w_result = w_src_a | w_alu_b;
            ALU_ADD: begin
                w_result = w_sum;
                w_ovf    = (w_src_a[31] == w_alu_b[31]) && (w_sum[31] != w_src_a[31]);
            end
            ALU_XOR:  w_result = w_src_a ^ w_alu_b;
            ALU_NOR:  w_result = ~(w_src_a | w_alu_b);
            ALU_SLL:  w_result = w_alu_b << bus.shamt;
            ALU_SUB: begin
                w_result = w_diff;
                w_ovf    = (w_src_a[31] != w_alu_b[31]) && (w_diff[31] != w_src_a[31]);
            end
            ALU_SLT:  w_result = {31'd0, $signed(w_src_a) < $signed(w_alu_b)};
            ALU_SRL:  w_result = w_alu_b >> bus.shamt;
            ALU_SRA:  w_result = $signed(w_alu_b) >>> bus.shamt;
            ALU_SLTU: w_result = {31'd0, w_src_a < w_alu_b};
            default:  w_result = '0;
        endcase
    end

    // Pipeline register: loads every cycle, cleared asynchronously by reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_alu_out_q    <= '0;
            r_store_data_q <= '0;
            r_overflow_q   <= 1'b0;
        end else begin
            r_alu_out_q    <= w_result;
            r_store_data_q <= w_src_b;
            r_overflow_q   <= w_ovf;
        end
    end

    assign bus.alu_con      = w_con;
    assign bus.alu_out      = w_result;
    assign bus.overflow     = w_ovf;
    assign bus.zero         = (w_result == '0);
    assign bus.alu_out_q    = r_alu_out_q;
    assign bus.store_data_q = r_store_data_q;
    assign bus.overflow_q   = r_overflow_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: combinational results checked as each step
// is driven, registered results queued and checked after the following edge.
module tb_alu_exec_unit;
    logic clock;
    logic reset;
    int   checks;
    int   failures;

    alu_exec_unit_if bus ();

    alu_exec_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] reg_a;
        logic [31:0] reg_b;
        logic [31:0] wb_data;
        logic [31:0] mem_alu;
        logic [1:0]  fwd_a;
        logic [1:0]  fwd_b;
        logic [31:0] imm_value;
        logic        alu_src;
        logic [1:0]  aluop;
        logic        andi;
        logic        ori;
        logic        addi;
        logic        slti;
        logic [4:0]  shamt;
    } step_t;

    typedef struct {
        string       tag;
        logic [31:0] alu_q;
        logic [31:0] sd_q;
        logic        ovf_q;
    } exp_t;

    exp_t sb[$];

    function automatic step_t dflt();
        step_t s;
        s.reg_a = '0; s.reg_b = '0; s.wb_data = '0; s.mem_alu = '0;
        s.fwd_a = 2'b00; s.fwd_b = 2'b00; s.imm_value = '0; s.alu_src = 1'b0;
        s.aluop = 2'b00; s.andi = 1'b0; s.ori = 1'b0; s.addi = 1'b0; s.slti = 1'b0;
        s.shamt = '0;
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input step_t s);
        bus.reg_a = s.reg_a; bus.reg_b = s.reg_b; bus.wb_data = s.wb_data;
        bus.mem_alu = s.mem_alu; bus.fwd_a = s.fwd_a; bus.fwd_b = s.fwd_b;
        bus.imm_value = s.imm_value; bus.alu_src = s.alu_src; bus.aluop = s.aluop;
        bus.andi = s.andi; bus.ori = s.ori; bus.addi = s.addi; bus.slti = s.slti;
        bus.shamt = s.shamt;
    endtask

    task automatic check_regs();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_alu_q"}, bus.alu_out_q, e.alu_q);
            chk({e.tag, "_sd_q"}, bus.store_data_q, e.sd_q);
            chk({e.tag, "_ovf_q"}, {31'd0, bus.overflow_q}, {31'd0, e.ovf_q});
        end
    endtask

    // Drive one step, check combinational outputs, queue the registered
    // expectation, then clock it through and check the pipeline register.
    task automatic run(input string tag, input step_t s, input logic [3:0] econ,
                       input logic [31:0] eout, input logic eovf, input logic [31:0] esd);
        exp_t e;
        drive(s);
        #1;
        chk({tag, "_con"}, {28'd0, bus.alu_con}, {28'd0, econ});
        chk({tag, "_out"}, bus.alu_out, eout);
        chk({tag, "_ovf"}, {31'd0, bus.overflow}, {31'd0, eovf});
        chk({tag, "_zero"}, {31'd0, bus.zero}, {31'd0, (eout == 32'd0)});
        e.tag = tag; e.alu_q = eout; e.sd_q = esd; e.ovf_q = eovf;
        sb.push_back(e);
        @(posedge clock);
        #1;
        check_regs();
    endtask

    initial begin
        step_t s;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;

        // Combinational path alive during reset, registers held at zero
        s = dflt(); s.reg_a = 32'd1; s.reg_b = 32'd2; s.aluop = 2'b00;
        drive(s);
        #1;
        chk("rst_comb_out", bus.alu_out, 32'd3);
        @(posedge clock);
        #1;
        chk("rst_alu_q", bus.alu_out_q, 32'd0);
        chk("rst_sd_q", bus.store_data_q, 32'd0);
        chk("rst_ovf_q", {31'd0, bus.overflow_q}, 32'd0);
        reset = 1'b0;

        s = dflt(); s.aluop = 2'b10; s.imm_value = 32'h20;
        s.reg_a = 32'h7FFFFFFF; s.reg_b = 32'd1;
        run("add_ovf", s, 4'b0010, 32'h80000000, 1'b1, 32'd1);

        s.imm_value = 32'h2A; s.reg_a = 32'hFFFFFFFF;
        run("slt", s, 4'b0111, 32'd1, 1'b0, 32'd1);
        s.imm_value = 32'h2B;
        run("sltu", s, 4'b1010, 32'd0, 1'b0, 32'd1);

        s = dflt(); s.aluop = 2'b10; s.imm_value = 32'h03; s.reg_b = 32'h80000000; s.shamt = 5'd4;
        run("sra", s, 4'b1001, 32'hF8000000, 1'b0, 32'h80000000);
        s.imm_value = 32'h02;
        run("srl", s, 4'b1000, 32'h08000000, 1'b0, 32'h80000000);
        s.imm_value = 32'h00; s.shamt = 5'd0; s.reg_b = 32'h12345678;
        run("sll0", s, 4'b0101, 32'h12345678, 1'b0, 32'h12345678);
        s.shamt = 5'd31; s.reg_b = 32'h00000003;
        run("sll31", s, 4'b0101, 32'h80000000, 1'b0, 32'h00000003);

        s = dflt(); s.aluop = 2'b10; s.reg_a = 32'hFF00FF00; s.reg_b = 32'h0F0F0F0F;
        s.imm_value = 32'h26; run("xor", s, 4'b0011, 32'hF00FF00F, 1'b0, 32'h0F0F0F0F);
        s.imm_value = 32'h27; run("nor", s, 4'b0100, 32'h00F000F0, 1'b0, 32'h0F0F0F0F);
        s.imm_value = 32'h24; run("and", s, 4'b0000, 32'h0F000F00, 1'b0, 32'h0F0F0F0F);
        s.imm_value = 32'h25; run("or", s, 4'b0001, 32'hFF0FFF0F, 1'b0, 32'h0F0F0F0F);
        s.imm_value = 32'h3F; run("bad_funct", s, 4'b0010, 32'h0E100E0F, 1'b0, 32'h0F0F0F0F);
        s.imm_value = 32'h23; run("subu", s, 4'b0110, 32'hEFF1EFF1, 1'b0, 32'h0F0F0F0F);

        s = dflt(); s.aluop = 2'b11; s.andi = 1'b1; s.ori = 1'b1; s.alu_src = 1'b1;
        s.reg_a = 32'hF0F0; s.reg_b = 32'hABCD; s.imm_value = 32'h00FF;
        run("andi_pri", s, 4'b0000, 32'h00F0, 1'b0, 32'hABCD);
        s.andi = 1'b0;
        run("ori", s, 4'b0001, 32'hF0FF, 1'b0, 32'hABCD);
        s.ori = 1'b0; s.addi = 1'b1; s.slti = 1'b1;
        run("addi_pri", s, 4'b0010, 32'hF1EF, 1'b0, 32'hABCD);
        s.addi = 1'b0;
        run("slti", s, 4'b0111, 32'd0, 1'b0, 32'hABCD);
        s.slti = 1'b0; s.imm_value = 32'hFFFFFFFF;
        run("noflag_add", s, 4'b0010, 32'h0000F0EF, 1'b0, 32'hABCD);

        s = dflt(); s.aluop = 2'b01; s.fwd_a = 2'b10; s.mem_alu = 32'd5;
        s.fwd_b = 2'b01; s.wb_data = 32'd3; s.reg_a = 32'h111; s.reg_b = 32'h222;
        run("fwd_sub", s, 4'b0110, 32'd2, 1'b0, 32'd3);
        s.fwd_a = 2'b11; s.fwd_b = 2'b11;
        run("fwd_zero", s, 4'b0110, 32'd0, 1'b0, 32'd0);
        s.fwd_a = 2'b01; s.fwd_b = 2'b10; s.aluop = 2'b00;
        run("fwd_wb_mem", s, 4'b0010, 32'd8, 1'b0, 32'd5);

        s = dflt(); s.aluop = 2'b01; s.reg_a = 32'h80000000; s.reg_b = 32'd1;
        run("sub_ovf", s, 4'b0110, 32'h7FFFFFFF, 1'b1, 32'd1);
        s.reg_a = 32'd0; s.reg_b = 32'h80000000;
        run("sub_ovf2", s, 4'b0110, 32'h80000000, 1'b1, 32'h80000000);
        s.reg_a = 32'h80000000; s.reg_b = 32'h80000000; s.aluop = 2'b00;
        run("add_wrap", s, 4'b0010, 32'd0, 1'b1, 32'h80000000);

        // Mid-cycle reset with nonzero registers and a result pending
        s = dflt(); s.reg_a = 32'h10; s.reg_b = 32'h20;
        drive(s);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_alu_q", bus.alu_out_q, 32'd0);
        chk("midrst_sd_q", bus.store_data_q, 32'd0);
        chk("midrst_ovf_q", {31'd0, bus.overflow_q}, 32'd0);
        chk("midrst_comb", bus.alu_out, 32'h30);
        @(posedge clock);
        #1;
        chk("midrst_discard", bus.alu_out_q, 32'd0);
        reset = 1'b0;

        s = dflt(); s.reg_a = 32'h1234; s.reg_b = 32'h1111;
        run("post_rst", s, 4'b0010, 32'h2345, 1'b0, 32'h1111);

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_left observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
